// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of the shift register.
// Bit time is SEQ / BAUD_RATE clk cycles, which must be at least 2.
module uart_tx #(
  parameter int SEQ        = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] data_in,
  output logic       full,
  output logic       overflow,
  output logic       TX,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int T_BAUD = SEQ / BAUD_RATE;
  localparam int CW     = (T_BAUD > 1) ? $clog2(T_BAUD) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] BAUD_LAST = CW'(T_BAUD - 1);
  localparam logic [CW-1:0] BAUD_PRE  = CW'(T_BAUD - 2);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          tx_busy_q, tx_busy_d;
  logic          tx_done_q, tx_done_d;

  logic full_s;
  logic push_s;
  logic pop_s;
  logic baud_end_s;
  logic fifo_ne_s;

  assign full_s     = (count_q == DEPTH_C);
  assign push_s     = wr_en & ~full_s;
  assign fifo_ne_s  = (count_q != {(AW + 1){1'b0}});
  assign baud_end_s = (baud_cnt_q == BAUD_LAST);

  // Next-state logic; outputs are derived from the next state so they leave flops.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    pop_s      = 1'b0;
    tx_done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fifo_ne_s) begin
          pop_s      = 1'b1;
          shift_d    = mem_q[rd_ptr_q];
          baud_cnt_d = {CW{1'b0}};
          state_d    = ST_START;
        end else begin
          baud_cnt_d = {CW{1'b0}};
        end
      end
      ST_START: begin
        if (baud_end_s) begin
          baud_cnt_d = {CW{1'b0}};
          bit_cnt_d  = 3'd0;
          state_d    = ST_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + {{(CW - 1){1'b0}}, 1'b1};
        end
      end
      ST_DATA: begin
        if (baud_end_s) begin
          baud_cnt_d = {CW{1'b0}};
          shift_d    = {1'b0, shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + {{(CW - 1){1'b0}}, 1'b1};
        end
      end
      ST_STOP: begin
        // tx_done is registered, so it is armed one cycle before the stop bit ends.
        tx_done_d = (baud_cnt_q == BAUD_PRE);
        if (baud_end_s) begin
          baud_cnt_d = {CW{1'b0}};
          if (fifo_ne_s) begin
            pop_s   = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + {{(CW - 1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d    = ST_IDLE;
        baud_cnt_d = {CW{1'b0}};
      end
    endcase

    case (state_d)
      ST_IDLE:  begin tx_d = 1'b1;       tx_busy_d = 1'b0; end
      ST_START: begin tx_d = 1'b0;       tx_busy_d = 1'b1; end
      ST_DATA:  begin tx_d = shift_d[0]; tx_busy_d = 1'b1; end
      ST_STOP:  begin tx_d = 1'b1;       tx_busy_d = 1'b1; end
      default:  begin tx_d = 1'b1;       tx_busy_d = 1'b0; end
    endcase
  end

  // FIFO bookkeeping; a write while full is dropped even if a pop happens in the same cycle.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{(AW - 1){1'b0}}, push_s};
    rd_ptr_d   = rd_ptr_q + {{(AW - 1){1'b0}}, pop_s};
    count_d    = count_q + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
    overflow_d = overflow_q | (wr_en & full_s);
  end

  // FIFO storage; contents are discarded on reset simply by clearing the pointers.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {(AW + 1){1'b0}};
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
      baud_cnt_q <= {CW{1'b0}};
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign full     = full_s;
  assign overflow = overflow_q;
  assign TX       = tx_q;
  assign tx_busy  = tx_busy_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx: a frame-position reference model predicts every output each
// cycle, and a behavioural line receiver decodes TX and matches bytes against accepted writes.
module tb_uart_tx;

  localparam int T     = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * T;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] data_in;
  logic       full;
  logic       overflow;
  logic       TX;
  logic       tx_busy;
  logic       tx_done;

  always #5 clk = ~clk;

  uart_tx #(.SEQ(16), .BAUD_RATE(1), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in),
    .full(full), .overflow(overflow), .TX(TX), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of buffered bytes plus the position inside the current frame.
  logic [7:0] fifo_m[$];
  logic [7:0] exp_q[$];
  bit         m_active;
  int         m_pos;
  logic [7:0] m_cur;
  bit         m_ovf;
  int         done_seen;

  bit         rx_busy;
  int         rx_cnt;
  logic [7:0] rx_byte;

  function automatic logic m_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_pos / T;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b - 1];
  endfunction

  task automatic model_reset();
    fifo_m.delete();
    exp_q.delete();
    m_active = 0;
    m_pos    = 0;
    m_ovf    = 0;
    rx_busy  = 0;
    rx_cnt   = 0;
  endtask

  task automatic model_edge(input bit wr, input logic [7:0] d);
    bit was_full, ending, start;
    was_full = (fifo_m.size() == DEPTH);
    ending   = m_active && (m_pos == FRAME - 1);
    start    = (!m_active || ending) && (fifo_m.size() > 0);
    if (wr && was_full) m_ovf = 1;
    if (m_active) begin
      m_pos++;
      if (ending) m_active = 0;
    end
    if (start) begin
      m_cur    = fifo_m.pop_front();
      m_active = 1;
      m_pos    = 0;
    end
    if (wr && !was_full) begin
      fifo_m.push_back(d);
      exp_q.push_back(d);
    end
  endtask

  task automatic compare_all();
    check("tx",       32'(TX),       32'(m_tx()));
    check("tx_busy",  32'(tx_busy),  32'(m_active));
    check("tx_done",  32'(tx_done),  32'(m_active && m_pos == FRAME - 1));
    check("full",     32'(full),     32'(fifo_m.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (tx_done === 1'b1) done_seen++;
  endtask

  // Line receiver: samples each bit in its middle, counting from the first low cycle.
  task automatic rx_sample();
    int n;
    if (!rx_busy) begin
      if (TX === 1'b0) begin
        rx_busy = 1;
        rx_cnt  = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == T / 2) check("rx_start", 32'(TX), 32'd0);
      if (rx_cnt >= T + T / 2 && rx_cnt < 9 * T && (rx_cnt - T / 2) % T == 0)
        rx_byte[(rx_cnt - T / 2) / T - 1] = TX;
      if (rx_cnt == 9 * T + T / 2) begin
        check("rx_stop", 32'(TX), 32'd1);
        n = exp_q.size();
        check("rx_queue_nonempty", 32'(n > 0), 32'd1);
        if (n > 0) check("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
        rx_busy = 0;
      end
    end
  endtask

  task automatic step(input bit wr, input logic [7:0] d);
    wr_en   = wr;
    data_in = d;
    @(posedge clk);
    if (!rst) model_edge(wr, d);
    @(negedge clk);
    compare_all();
    rx_sample();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  logic [7:0] loop_bytes [5] = '{8'h00, 8'hFF, 8'h3C, 8'h81, 8'h5A};

  initial begin
    int i;
    rst     = 1'b1;
    wr_en   = 1'b0;
    data_in = 8'h00;
    model_reset();
    done_seen = 0;
    repeat (3) @(negedge clk);
    compare_all();
    rst = 1'b0;
    idle(200);

    // Single byte, exact frame timing checked every cycle by the model.
    done_seen = 0;
    step(1'b1, 8'hA5);
    idle(180);
    check("a5_done_count", 32'(done_seen), 32'd1);
    check("a5_rx_drained", 32'(exp_q.size()), 32'd0);

    // Back-to-back frames decoded by the line receiver.
    done_seen = 0;
    foreach (loop_bytes[k]) step(1'b1, loop_bytes[k]);
    idle(5 * FRAME + 40);
    check("loop_done_count", 32'(done_seen), 32'd5);
    check("loop_rx_drained", 32'(exp_q.size()), 32'd0);

    // Six writes in a row: the sixth is dropped.
    done_seen = 0;
    for (int k = 0; k < 5; k++) step(1'b1, 8'($urandom));
    check("full_after_5th", 32'(full), 32'd1);
    step(1'b1, 8'($urandom));
    check("overflow_after_6th", 32'(overflow), 32'd1);
    idle(5 * FRAME + 40);
    check("ovf_done_count", 32'(done_seen), 32'd5);

    // Reset in the middle of data bit 3 of a zero byte, with two bytes queued.
    step(1'b1, 8'h00);
    step(1'b1, 8'($urandom));
    step(1'b1, 8'($urandom));
    for (i = 0; i < 400 && !(m_active && m_pos == 4 * T + 5); i++) step(1'b0, 8'h00);
    check("reached_bit3", 32'(i < 400), 32'd1);
    check("tx_low_before_rst", 32'(TX), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rst_tx_immediate", 32'(TX), 32'd1);
    check("rst_busy_immediate", 32'(tx_busy), 32'd0);
    model_reset();
    done_seen = 0;
    idle(4);
    #2 rst = 1'b0;
    idle(200);
    check("rst_no_done", 32'(done_seen), 32'd0);

    // Write while full on the cycle the stop bit ends and pops the next byte.
    done_seen = 0;
    for (int k = 0; k < 5; k++) step(1'b1, 8'($urandom));
    for (i = 0; i < 400 && !(m_active && m_pos == FRAME - 1); i++) step(1'b0, 8'h00);
    check("reached_stop_end", 32'(i < 400), 32'd1);
    check("full_at_stop_end", 32'(full), 32'd1);
    step(1'b1, 8'h77);
    check("pop_write_overflow", 32'(overflow), 32'd1);
    check("pop_write_full", 32'(full), 32'd0);
    idle(4 * FRAME + 40);
    check("pop_write_done_count", 32'(done_seen), 32'd5);
    check("pop_write_rx_drained", 32'(exp_q.size()), 32'd0);

    // Random traffic.
    for (int k = 0; k < 3000; k++) step($urandom_range(0, 9) == 0, 8'($urandom));
    idle(5 * FRAME + 40);
    check("rand_rx_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Byte-serial UART transmitter with a small input FIFO.
- Produces an 8N1 frame on TX: start bit, 8 data bits LSB first, 1 stop bit.
- Sits directly upstream of uart_rx; its TX pin drives uart_rx's RX input, on the board and in loopback benches.
- Uses the same clock-frequency and baud parameters as uart_rx, so both ends agree on bit time.

Parameters:
- SEQ, 100000000, clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bit/s.
  - T_baud = SEQ / BAUD_RATE, using integer division; this is the number of clk cycles per bit.
  - With the defaults, T_baud = 10416.
- FIFO_DEPTH, 4, number of bytes buffered ahead of the shifter.
  - Must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- wr_en  in  1  write strobe for data_in.
- data_in  in  8  byte to transmit.
- full  out  1  FIFO holds FIFO_DEPTH bytes.
- overflow  out  1  sticky: a write was attempted while full.
- TX  out  1  serial line; idle high.
- tx_busy  out  1  a frame is in progress.
- tx_done  out  1  one-cycle pulse at the end of each stop bit.

Behaviour:
- Clocking and reset (already decided): one clock; reset is asynchronous and active-high.
- Reset values:
  - TX=1, tx_busy=0, tx_done=0, full=0, overflow=0.
  - FIFO empty; FSM in IDLE; all counters 0.
- Reset asserted mid-frame:
  - TX returns to 1 immediately (asynchronously).
  - The frame is abandoned and FIFO contents are discarded.
  - No tx_done pulse is generated.
- FIFO write:
  - At a rising edge with wr_en=1 and full=0, data_in is stored.
  - At a rising edge with wr_en=1 and full=1, the byte is dropped and overflow is set.
  - overflow stays set until rst.
  - full is computed from the registered count. A write in the same cycle as a pop while full is still dropped.
- FSM states: IDLE, START, DATA, STOP. All outputs are registered.
- IDLE:
  - TX=1, tx_busy=0.
  - If the FIFO is non-empty at an edge: pop the head byte into the shift register, clear baud_cnt, go to START.
  - From a write into an empty FIFO at edge N, TX is low after edge N+1.
- START:
  - TX=0 for exactly T_baud cycles.
  - On baud_cnt == T_baud-1: clear baud_cnt and bit_cnt, go to DATA.
- DATA:
  - TX = shift[0].
  - On each baud_cnt == T_baud-1: shift right by 1 and increment bit_cnt.
  - After bit_cnt reaches 7 and that bit completes, go to STOP.
  - Each data bit is held exactly T_baud cycles.
- STOP:
  - TX=1 for T_baud cycles.
  - On the last cycle, tx_done pulses high for exactly 1 cycle.
  - If the FIFO is non-empty: pop and go directly to START, so the next start bit immediately follows the stop bit with no idle gap.
  - Otherwise go to IDLE.
- tx_busy is 1 in START, DATA and STOP.
- Frame length is 10*T_baud cycles exactly.
- Counters:
  - baud_cnt is wide enough for T_baud-1 and wraps to 0 only by explicit clear.
  - bit_cnt is 3 bits.
- FIFO pointers:
  - log2(FIFO_DEPTH) bits, wrapping naturally.
  - count is log2(FIFO_DEPTH)+1 bits.
- data_in changes after acceptance do not affect the byte already stored.

Test Plan:
- Bench parameters: SEQ=16, BAUD_RATE=1, so T_baud=16.
- Reset then idle, no writes -> TX=1, tx_busy=0, full=0 for 200 cycles.
- Single write 0xA5 at edge N:
  - TX=0 from N+1 for 16 cycles.
  - Then bits 1,0,1,0,0,1,0,1 at 16 cycles each.
  - Then 1 for 16 cycles.
  - tx_done high only at cycle N+160; tx_busy falls after it.
- Loopback through uart_rx (rd_en=1):
  - Write 0x00, 0xFF, 0x3C, 0x81, 0x5A back-to-back.
  - Five frames with no idle gap between stop bit and next start bit.
  - uart_rx data_out matches each byte in order, with one rd_done per byte.
- Full/overflow:
  - Write 6 bytes on consecutive cycles.
  - full=1 after the 5th accepted write, because 1 byte is popped into the shifter and 4 are buffered.
  - The 6th write is dropped and overflow=1.
  - Exactly 5 frames are transmitted.
- Reset mid-frame:
  - Assert rst during bit 3 of frame 1 with 2 bytes queued.
  - TX=1 immediately; tx_done never pulses.
  - After release, TX stays 1 and full=0.
- Write while full with simultaneous STOP-end pop -> byte dropped, overflow=1, count decreases by 1.
